// File: rtl/starfield_ramp_ctrl.sv
// starfield_ramp_ctrl
// Frame-synchronous velocity ramp controller for the starfield generator.
// Holds CPU-written H/V target velocities, steps the current velocities toward
// them once per frame on a vblank edge, and programs the starfield registers
// over its write bus. CPU enable writes are forwarded on the same bus.
module starfield_ramp_ctrl #(
   parameter logic [7:0] STEP_RESET = 8'd0,
   parameter logic       EN_RESET   = 1'b0,
   parameter bit         VB_RISING  = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vblank,
   input  logic [2:0]         cpu_addr,
   input  logic [7:0]         cpu_data_in,
   input  logic               cpu_write,
   output logic [2:0]         sf_addr,
   output logic [7:0]         sf_data,
   output logic               sf_write,
   output logic               busy,
   output logic signed [15:0] h_speed,
   output logic signed [15:0] v_speed,
   output logic               at_target
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WR_EN,
      S_WR_H1,
      S_WR_H2,
      S_WR_V1,
      S_WR_V2
   } state_t;

   // One ramp step from cur toward tgt; a zero step or a remaining distance
   // within one step lands exactly on the target.
   function automatic logic signed [15:0] ramp_toward(input logic signed [15:0] cur,
                                                      input logic signed [15:0] tgt,
                                                      input logic [7:0]         step);
      logic signed [16:0] diff;
      logic [16:0]        adiff;
      logic signed [15:0] res;
      diff  = $signed({tgt[15], tgt}) - $signed({cur[15], cur});
      adiff = diff[16] ? -diff : diff;
      if (step == 8'd0 || adiff <= {9'd0, step})
         res = tgt;
      else if (diff[16])
         res = cur - $signed({8'd0, step});
      else
         res = cur + $signed({8'd0, step});
      return res;
   endfunction

   // Starfield register format {dir, mag[14:0]}, dir=1 for zero/positive.
   function automatic logic [15:0] sf_encode(input logic signed [15:0] v);
      logic signed [15:0] a;
      a = v[15] ? -v : v;
      return {~v[15], a[14:0]};
   endfunction

   // CPU target format {dir, mag[14:8]}, mag[7:0] to a signed velocity.
   function automatic logic signed [15:0] tgt_decode(input logic [7:0] hi,
                                                     input logic [7:0] lo);
      logic signed [15:0] m;
      m = $signed({1'b0, hi[6:0], lo});
      return hi[7] ? m : -m;
   endfunction

   state_t             state, state_nx;
   logic               vb_q;
   logic               trig;
   logic [7:0]         h_hold, v_hold;
   logic signed [15:0] h_tgt, v_tgt;
   logic [7:0]         step;
   logic               en, en_nx;
   logic               en_wr, en_req;
   logic               en_pending, vb_pending;
   logic               h_dirty, v_dirty;
   logic signed [15:0] h_calc, v_calc;
   logic               h_dirty_calc, v_dirty_calc;
   logic               start_calc;
   logic signed [15:0] h_out, v_out;
   logic [15:0]        h_enc, v_enc;
   logic [2:0]         wr_addr_nx;
   logic [7:0]         wr_data_nx;
   logic               wr_nx;

   assign trig         = VB_RISING ? (vblank & ~vb_q) : (~vblank & vb_q);
   assign en_wr        = cpu_write && (cpu_addr == 3'd0);
   assign en_req       = en_pending | en_wr;
   assign en_nx        = en_wr ? cpu_data_in[0] : en;
   assign h_calc       = ramp_toward(h_speed, h_tgt, step);
   assign v_calc       = ramp_toward(v_speed, v_tgt, step);
   assign h_dirty_calc = h_dirty | (h_calc != h_speed);
   assign v_dirty_calc = v_dirty | (v_calc != v_speed);
   assign start_calc   = (state == S_IDLE) && !en_req && (trig || vb_pending);
   assign h_out        = (state == S_CALC) ? h_calc : h_speed;
   assign v_out        = (state == S_CALC) ? v_calc : v_speed;
   assign h_enc        = sf_encode(h_out);
   assign v_enc        = sf_encode(v_out);
   assign busy         = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next state plus the write-bus values that go with the state being entered.
   always_comb begin
      state_nx   = state;
      wr_addr_nx = 3'd0;
      wr_data_nx = 8'd0;
      unique case (state)
         S_IDLE: begin
            if (en_req)                  state_nx = S_WR_EN;
            else if (trig || vb_pending) state_nx = S_CALC;
         end
         S_CALC: begin
            if (h_dirty_calc)      state_nx = S_WR_H1;
            else if (v_dirty_calc) state_nx = S_WR_V1;
            else                   state_nx = S_IDLE;
         end
         S_WR_EN: state_nx = S_IDLE;
         S_WR_H1: state_nx = S_WR_H2;
         S_WR_H2: state_nx = v_dirty ? S_WR_V1 : S_IDLE;
         S_WR_V1: state_nx = S_WR_V2;
         S_WR_V2: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      case (state_nx)
         S_WR_EN: begin wr_addr_nx = 3'd0; wr_data_nx = {7'd0, en_nx}; end
         S_WR_H1: begin wr_addr_nx = 3'd1; wr_data_nx = h_enc[15:8];   end
         S_WR_H2: begin wr_addr_nx = 3'd2; wr_data_nx = h_enc[7:0];    end
         S_WR_V1: begin wr_addr_nx = 3'd3; wr_data_nx = v_enc[15:8];   end
         S_WR_V2: begin wr_addr_nx = 3'd4; wr_data_nx = v_enc[7:0];    end
         default: begin wr_addr_nx = 3'd0; wr_data_nx = 8'd0;          end
      endcase
      wr_nx = (state_nx == S_WR_EN) || (state_nx == S_WR_H1) || (state_nx == S_WR_H2) ||
              (state_nx == S_WR_V1) || (state_nx == S_WR_V2);
   end

   // Registered starfield bus; address/data hold their last value between writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sf_addr  <= 3'd0;
         sf_data  <= 8'd0;
         sf_write <= 1'b0;
      end else begin
         sf_write <= wr_nx;
         if (wr_nx) begin
            sf_addr <= wr_addr_nx;
            sf_data <= wr_data_nx;
         end
      end
   end

   // CPU register file: high bytes wait in a hold register until the low byte commits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en     <= EN_RESET;
         h_hold <= 8'd0;
         v_hold <= 8'd0;
         h_tgt  <= '0;
         v_tgt  <= '0;
         step   <= STEP_RESET;
      end else if (cpu_write) begin
         case (cpu_addr)
            3'd0:    en     <= cpu_data_in[0];
            3'd1:    h_hold <= cpu_data_in;
            3'd2:    h_tgt  <= tgt_decode(h_hold, cpu_data_in);
            3'd3:    v_hold <= cpu_data_in;
            3'd4:    v_tgt  <= tgt_decode(v_hold, cpu_data_in);
            3'd5:    step   <= cpu_data_in;
            default: ;
         endcase
      end
   end

   // Trigger and enable request tracking; a single pending trigger is remembered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vb_q       <= 1'b0;
         vb_pending <= 1'b0;
         en_pending <= 1'b1;
      end else begin
         vb_q <= vblank;
         if (start_calc)  vb_pending <= vb_pending & trig;
         else if (trig)   vb_pending <= 1'b1;
         if (en_wr)                 en_pending <= 1'b1;
         else if (state == S_WR_EN) en_pending <= 1'b0;
      end
   end

   // Velocity update in CALC; dirty flags clear on the second write of each pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_speed   <= '0;
         v_speed   <= '0;
         at_target <= 1'b1;
         h_dirty   <= 1'b1;
         v_dirty   <= 1'b1;
      end else begin
         if (state == S_CALC) begin
            h_speed   <= h_calc;
            v_speed   <= v_calc;
            at_target <= (h_calc == h_tgt) && (v_calc == v_tgt);
            h_dirty   <= h_dirty_calc;
            v_dirty   <= v_dirty_calc;
         end else begin
            if (state == S_WR_H2) h_dirty <= 1'b0;
            if (state == S_WR_V2) v_dirty <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_starfield_ramp_ctrl.sv
// Bench for starfield_ramp_ctrl: table of per-frame targets with expected
// velocities, a write-bus scoreboard, and hand-built multi-cycle sequences.
module tb_starfield_ramp_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               vblank = 1'b0;
   logic [2:0]         cpu_addr = 3'd0;
   logic [7:0]         cpu_data_in = 8'd0;
   logic               cpu_write = 1'b0;
   logic [2:0]         sf_addr;
   logic [7:0]         sf_data;
   logic               sf_write;
   logic               busy;
   logic signed [15:0] h_speed, v_speed;
   logic               at_target;

   starfield_ramp_ctrl dut (
      .clk(clk), .rst_n(rst_n), .vblank(vblank),
      .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_write(cpu_write),
      .sf_addr(sf_addr), .sf_data(sf_data), .sf_write(sf_write),
      .busy(busy), .h_speed(h_speed), .v_speed(v_speed), .at_target(at_target)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [10:0] q[$];

   typedef struct {
      logic [7:0]         step;
      logic signed [15:0] h_tgt;
      logic signed [15:0] v_tgt;
      logic signed [15:0] exp_h;
      logic signed [15:0] exp_v;
      logic               exp_at;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl[NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", nm, act, exp);
   endtask

   function automatic logic [15:0] enc(input logic signed [15:0] v);
      logic [15:0] m;
      m = (v < 0) ? 16'(-v) : 16'(v);
      return {(v >= 0), m[14:0]};
   endfunction

   task automatic push_axis(input int axis, input logic signed [15:0] v);
      logic [15:0] e;
      e = enc(v);
      q.push_back({(axis == 0) ? 3'd1 : 3'd3, e[15:8]});
      q.push_back({(axis == 0) ? 3'd2 : 3'd4, e[7:0]});
   endtask

   // Scoreboard: every bus write must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && sf_write) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL sf_write: got addr %0d data %h, required no write", sf_addr, sf_data);
         end else begin
            logic [10:0] e;
            e = q.pop_front();
            chk("sf_write", {21'd0, sf_addr, sf_data}, {21'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_data_in = d; cpu_write = 1'b1;
      tick();
      cpu_write = 1'b0;
   endtask

   task automatic set_tgt(input int axis, input logic signed [15:0] v);
      logic [15:0] e;
      e = enc(v);
      cpu_wr((axis == 0) ? 3'd1 : 3'd3, e[15:8]);
      cpu_wr((axis == 0) ? 3'd2 : 3'd4, e[7:0]);
   endtask

   // One vblank pulse; returns number of busy cycles of the resulting sequence.
   task automatic frame(output int bc);
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         bc++;
         tick();
      end
      chk("frame_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      logic hw, vw, hd, vd;
      logic signed [15:0] ph, pv;
      logic [3:0] bp;

      tbl[0]  = '{8'h00,  16'sh0100,  16'sh0000,  16'sh0100,  16'sh0000, 1'b1};
      tbl[1]  = '{8'h00,  16'sh0000,  16'sh0000,  16'sh0000,  16'sh0000, 1'b1};
      tbl[2]  = '{8'h40,  16'sh0100,  16'sh0000,  16'sh0040,  16'sh0000, 1'b0};
      tbl[3]  = '{8'h40,  16'sh0100,  16'sh0000,  16'sh0080,  16'sh0000, 1'b0};
      tbl[4]  = '{8'h40,  16'sh0100,  16'sh0000,  16'sh00C0,  16'sh0000, 1'b0};
      tbl[5]  = '{8'h40,  16'sh0100,  16'sh0000,  16'sh0100,  16'sh0000, 1'b1};
      tbl[6]  = '{8'h40,  16'sh0100,  16'sh0000,  16'sh0100,  16'sh0000, 1'b1};
      tbl[7]  = '{8'h00,  16'sh0030,  16'sh0000,  16'sh0030,  16'sh0000, 1'b1};
      tbl[8]  = '{8'h40, -16'sh0050,  16'sh0000, -16'sh0010,  16'sh0000, 1'b0};
      tbl[9]  = '{8'h40, -16'sh0050,  16'sh0000, -16'sh0050,  16'sh0000, 1'b1};
      tbl[10] = '{8'h20, -16'sh0050, -16'sh7FFF, -16'sh0050, -16'sh0020, 1'b0};
      tbl[11] = '{8'h00, -16'sh0050,  16'sh7FFF, -16'sh0050,  16'sh7FFF, 1'b1};
      tbl[12] = '{8'hFF, -16'sh0050, -16'sh7FFF, -16'sh0050,  16'sh7F00, 1'b0};
      tbl[13] = '{8'h00,  16'sh1234, -16'sh0001,  16'sh1234, -16'sh0001, 1'b1};

      // Reset state
      #12;
      chk("rst_sf_write", {31'd0, sf_write}, 32'd0);
      chk("rst_sf_addr", {29'd0, sf_addr}, 32'd0);
      chk("rst_sf_data", {24'd0, sf_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_h_speed", {16'd0, h_speed}, 32'd0);
      chk("rst_v_speed", {16'd0, v_speed}, 32'd0);
      chk("rst_at_target", {31'd0, at_target}, 32'd1);

      // Reset leaves an enable write pending (EN_RESET=0)
      q.push_back({3'd0, 8'h00});
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_en_write_seen", q.size(), 0);

      // Table-driven frames
      hd = 1'b1; vd = 1'b1; ph = '0; pv = '0;
      for (int i = 0; i < NV; i++) begin
         cpu_wr(3'd5, tbl[i].step);
         set_tgt(0, tbl[i].h_tgt);
         set_tgt(1, tbl[i].v_tgt);
         hw = hd || (tbl[i].exp_h != ph);
         vw = vd || (tbl[i].exp_v != pv);
         if (hw) push_axis(0, tbl[i].exp_h);
         if (vw) push_axis(1, tbl[i].exp_v);
         hd = 1'b0; vd = 1'b0;
         frame(bc);
         chk($sformatf("tbl%0d_h_speed", i), {{16{h_speed[15]}}, h_speed}, {{16{tbl[i].exp_h[15]}}, tbl[i].exp_h});
         chk($sformatf("tbl%0d_v_speed", i), {{16{v_speed[15]}}, v_speed}, {{16{tbl[i].exp_v[15]}}, tbl[i].exp_v});
         chk($sformatf("tbl%0d_at_target", i), {31'd0, at_target}, {31'd0, tbl[i].exp_at});
         chk($sformatf("tbl%0d_busy_cycles", i), bc, 1 + 2 * int'(hw) + 2 * int'(vw));
         chk($sformatf("tbl%0d_writes_done", i), q.size(), 0);
         ph = tbl[i].exp_h; pv = tbl[i].exp_v;
      end

      // Enable write and vblank edge in the same cycle: enable goes first
      q.push_back({3'd0, 8'h01});
      cpu_addr = 3'd0; cpu_data_in = 8'h01; cpu_write = 1'b1; vblank = 1'b1;
      tick();
      cpu_write = 1'b0; vblank = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bp[k] = busy;
         tick();
      end
      chk("en_before_calc_busy", {28'd0, bp}, 32'h5);
      chk("en_before_calc_writes", q.size(), 0);
      q.push_back({3'd0, 8'h00});
      cpu_wr(3'd0, 8'h00);
      repeat (3) tick();
      chk("en_clear_write", q.size(), 0);

      // High byte alone does not change the target; low byte commits it
      cpu_wr(3'd1, 8'h85);
      frame(bc);
      chk("hold_only_h_speed", {16'd0, h_speed}, 32'h1234);
      chk("hold_only_busy", bc, 1);
      q.push_back({3'd1, 8'h85});
      q.push_back({3'd2, 8'h00});
      cpu_wr(3'd2, 8'h00);
      frame(bc);
      chk("commit_h_speed", {16'd0, h_speed}, 32'h0500);
      chk("commit_busy", bc, 3);

      // One extra edge while busy runs one more sequence
      cpu_wr(3'd5, 8'h10);
      set_tgt(0, 16'sh0400);
      push_axis(0, 16'sh04F0);
      push_axis(0, 16'sh04E0);
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
      vblank = 1'b1; tick();
      vblank = 1'b0;
      repeat (20) tick();
      chk("pend1_h_speed", {16'd0, h_speed}, 32'h04E0);
      chk("pend1_writes", q.size(), 0);
      chk("pend1_idle", {31'd0, busy}, 32'd0);

      // Two extra edges while busy still give only one more sequence
      set_tgt(1, -16'sh0101);
      push_axis(0, 16'sh04D0);
      push_axis(1, -16'sh0011);
      push_axis(0, 16'sh04C0);
      push_axis(1, -16'sh0021);
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
      vblank = 1'b1; tick();
      vblank = 1'b0;
      repeat (25) tick();
      chk("pend2_h_speed", {16'd0, h_speed}, 32'h04C0);
      chk("pend2_v_speed", {{16{v_speed[15]}}, v_speed}, 32'hFFFF_FFDF);
      chk("pend2_writes", q.size(), 0);

      // Reset in the middle of a write sequence aborts at once
      cpu_wr(3'd5, 8'h00);
      set_tgt(0, 16'sh0000);
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
      chk("abort_pre_write", {31'd0, sf_write}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_sf_write", {31'd0, sf_write}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_sf_addr", {29'd0, sf_addr}, 32'd0);
      chk("abort_at_target", {31'd0, at_target}, 32'd1);
      q.delete();
      q.push_back({3'd0, 8'h00});
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      push_axis(0, 16'sh0000);
      push_axis(1, 16'sh0000);
      frame(bc);
      chk("post_rst_busy", bc, 5);
      chk("post_rst_h_speed", {16'd0, h_speed}, 32'd0);
      chk("post_rst_writes", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
